// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encoding shared by the ALU datapath, top and bench
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_PASSA = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_AND   = 3'b011,
    OP_OR    = 3'b100,
    OP_XOR   = 3'b101,
    OP_NOT   = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

endpackage

// File: rtl/alu_8b_datapath.sv
// rtl/alu_8b_datapath.sv - combinational next result and (ALU8B_FLAGS_EN) next flags
module alu_8b_datapath
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  logic [OP_W-1:0] op,
  output logic [N-1:0]    result
`ifdef ALU8B_FLAGS_EN
  ,
  output logic            zero_nxt,
  output logic            carry_nxt,
  output logic            ovf_nxt
`endif
);

  // One extra bit on both adders so the MSB is the carry-out.
  logic [N:0] sum_w;
  logic [N:0] diff_w;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  // Subtract as a + ~b + 1; carry-out set means no borrow.
  assign diff_w = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};

  // Result mux; unknown opcodes fall back to passing the accumulator through.
  always_comb begin
    result = a;
    case (op_e'(op))
      OP_PASSA: result = a;
      OP_ADD:   result = sum_w[N-1:0];
      OP_SUB:   result = diff_w[N-1:0];
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOT:   result = ~a;
      OP_PASSB: result = b;
      default:  result = a;
    endcase
  end

`ifdef ALU8B_FLAGS_EN
  // Flags: carry/ovf only meaningful for ADD and SUB, zero for every op.
  always_comb begin
    zero_nxt  = (result == '0);
    carry_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        carry_nxt = sum_w[N];
        ovf_nxt   = (a[N-1] == b[N-1]) && (sum_w[N-1] != a[N-1]);
      end
      OP_SUB: begin
        carry_nxt = ~diff_w[N];
        ovf_nxt   = (a[N-1] != b[N-1]) && (diff_w[N-1] != a[N-1]);
      end
      default: begin
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
      end
    endcase
  end
`else
  logic unused_carry;
  assign unused_carry = sum_w[N] ^ diff_w[N];
`endif

endmodule

// File: rtl/alu_8b.sv
// rtl/alu_8b.sv - registered accumulator ALU top; ALU8B_FLAGS_EN adds zero/carry/ovf
module alu_8b
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    data,
  input  logic [N-1:0]    accum,
  input  logic [OP_W-1:0] op,
  output logic [N-1:0]    out
`ifdef ALU8B_FLAGS_EN
  ,
  output logic            zero,
  output logic            carry,
  output logic            ovf
`endif
);

  logic [N-1:0] result;

`ifdef ALU8B_FLAGS_EN
  logic zero_nxt;
  logic carry_nxt;
  logic ovf_nxt;
`endif

  alu_8b_datapath #(.N(N)) u_datapath (
    .a        (accum),
    .b        (data),
    .op       (op),
    .result   (result)
`ifdef ALU8B_FLAGS_EN
    ,
    .zero_nxt (zero_nxt),
    .carry_nxt(carry_nxt),
    .ovf_nxt  (ovf_nxt)
`endif
  );

  // Result register, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= result;
  end

`ifdef ALU8B_FLAGS_EN
  // Flag registers; zero resets high to match the cleared result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero  <= 1'b1;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      zero  <= zero_nxt;
      carry <= carry_nxt;
      ovf   <= ovf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_alu_8b.sv
// tb/tb_alu_8b.sv - self-checking bench for alu_8b, with or without ALU8B_FLAGS_EN
module tb_alu_8b;

  localparam int N    = 8;
  localparam int MODV = 256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] data;
  logic [N-1:0] accum;
  logic [2:0]   op;
  logic [N-1:0] out;
`ifdef ALU8B_FLAGS_EN
  logic         zero;
  logic         carry;
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  alu_8b #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .data (data),
    .accum(accum),
    .op   (op),
    .out  (out)
`ifdef ALU8B_FLAGS_EN
    ,
    .zero (zero),
    .carry(carry),
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic int to_signed(input int v);
    return (v >= MODV / 2) ? v - MODV : v;
  endfunction

  function automatic void ref_model(input int o, input int a, input int b,
                                    output int r, output int z, output int c, output int v);
    int sa, sb, full;
    sa = to_signed(a);
    sb = to_signed(b);
    c  = 0;
    v  = 0;
    case (o)
      1: begin
        full = a + b;
        r    = full % MODV;
        c    = (full >= MODV) ? 1 : 0;
        v    = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0;
      end
      2: begin
        r = (a - b + MODV) % MODV;
        c = (a < b) ? 1 : 0;
        v = ((sa - sb) > 127 || (sa - sb) < -128) ? 1 : 0;
      end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (MODV - 1) - a;
      7: r = b;
      default: r = a;
    endcase
    z = (r == 0) ? 1 : 0;
  endfunction

  task automatic apply(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    op    = o;
    accum = a;
    data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(3'b000, 8'h5A, 8'h00);
    checks++;
    if (out !== 8'h5A) begin
      errors++;
      $display("FAIL reset_pre out=%h exp=5a", out);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("FAIL reset_async out=%h exp=00", out);
    end
`ifdef ALU8B_FLAGS_EN
    checks++;
    if ({zero, carry, ovf} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags zco=%b exp=100", {zero, carry, ovf});
    end
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold out=%h exp=00", out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [N-1:0] exp_tab [8];
    exp_tab = '{8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h7F, 8'h7F, 8'h80, 8'h00};
    for (int i = 0; i < 8; i++) begin
      apply(3'(i), 8'h7F, 8'h00);
      checks++;
      if (out !== exp_tab[i]) begin
        errors++;
        $display("FAIL sweep op=%0d out=%h exp=%h", i, out, exp_tab[i]);
      end
    end
  endtask

  task automatic test_add_sub();
    logic [2:0]   ops [4];
    logic [N-1:0] as  [4];
    logic [N-1:0] bs  [4];
    logic [N-1:0] rs  [4];
    logic [2:0]   zcv [4];
    ops = '{3'b001, 3'b001, 3'b010, 3'b010};
    as  = '{8'h7F, 8'hFF, 8'h00, 8'h80};
    bs  = '{8'h01, 8'h01, 8'h01, 8'h01};
    rs  = '{8'h80, 8'h00, 8'hFF, 8'h7F};
    zcv = '{3'b001, 3'b110, 3'b010, 3'b001};
    for (int i = 0; i < 4; i++) begin
      apply(ops[i], as[i], bs[i]);
      checks++;
      if (out !== rs[i]) begin
        errors++;
        $display("FAIL arith_%0d out=%h exp=%h", i, out, rs[i]);
      end
`ifdef ALU8B_FLAGS_EN
      checks++;
      if ({zero, carry, ovf} !== zcv[i]) begin
        errors++;
        $display("FAIL arith_flags_%0d zco=%b exp=%b", i, {zero, carry, ovf}, zcv[i]);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   ops [3];
    logic [N-1:0] rs  [3];
    ops = '{3'b011, 3'b100, 3'b101};
    rs  = '{8'h30, 8'hFC, 8'hCC};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op    = ops[i];
      accum = 8'hF0;
      data  = 8'h3C;
      #1;
      if (i > 0) begin
        checks++;
        if (out !== rs[i-1]) begin
          errors++;
          $display("FAIL b2b_hold_%0d out=%h exp=%h", i, out, rs[i-1]);
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if (out !== rs[i]) begin
        errors++;
        $display("FAIL b2b_%0d out=%h exp=%h", i, out, rs[i]);
      end
    end
  endtask

  task automatic test_random();
    int o, a, b, r, z, c, v;
    for (int i = 0; i < 10000; i++) begin
      o = int'($urandom_range(0, 7));
      a = int'($urandom_range(0, MODV - 1));
      b = int'($urandom_range(0, MODV - 1));
      ref_model(o, a, b, r, z, c, v);
      apply(3'(o), N'(a), N'(b));
      checks++;
      if (int'(out) !== r) begin
        errors++;
        $display("FAIL rand op=%0d a=%h b=%h out=%h exp=%h", o, a, b, out, r);
      end
`ifdef ALU8B_FLAGS_EN
      checks++;
      if ({zero, carry, ovf} !== {z[0], c[0], v[0]}) begin
        errors++;
        $display("FAIL rand_flags op=%0d a=%h b=%h zco=%b exp=%b",
                 o, a, b, {zero, carry, ovf}, {z[0], c[0], v[0]});
      end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    op    = 3'b000;
    accum = '0;
    data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_sweep();
    test_add_sub();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
